partition_kv_sender: RTL and testbench

- Per-partitioner output stage sitting directly upstream of the reduce arbiter.
- Buffers <key,value> pairs produced by one partitioner in a small FIFO.
- Raises a request toward the reduce arbiter and, once acknowledged, serializes each DIMENSION*PRECISION value onto a PRECISION-wide crossbar lane, one dimension per cycle, while holding the key stable.
- One instance per partitioner; its lane output is one PRECISION slice of the arbiter's value input bus.

---
 rtl/partition_kv_sender_pkg.sv | 11 +
 rtl/kv_sync_fifo.sv | 48 ++++
 rtl/partition_kv_sender.sv | 116 +++++++++++
 tb/tb_partition_kv_sender.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/partition_kv_sender_pkg.sv
// partition_kv_sender_pkg: key width and sender FSM state encodings shared by the
// partition output stage.
package partition_kv_sender_pkg;
  localparam int KEY_W = 16;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    HOLD = 2'b10,
    SEND = 2'b11
  } state_t;
endpackage

// File: rtl/kv_sync_fifo.sv
// kv_sync_fifo: circular-buffer FIFO whose head word is always visible on rd_data;
// a push while full is accepted only when a pop happens in the same cycle.
module kv_sync_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push, pop;
  always_comb begin
    pop      = rd_en && count_q != '0;
    push     = wr_en && (count_q != FULL_CNT || pop);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end
  assign rd_data = mem_q[rd_ptr_q];
  assign full    = count_q == FULL_CNT;
  assign empty   = count_q == '0;
  assign count   = count_q;
endmodule

// File: rtl/partition_kv_sender.sv
// partition_kv_sender: buffers <key,value> pairs and serializes each value onto a
// PRECISION-wide lane after the reduce arbiter acks. PARTITION_KV_STATS_EN adds o_sent_count.
module partition_kv_sender
  import partition_kv_sender_pkg::*;
#(
  parameter int PRECISION = 16,
  parameter int DIMENSION = 2,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           i_wr_en,
  input  logic [KEY_W-1:0]               i_key,
  input  logic [PRECISION*DIMENSION-1:0] i_value,
  output logic                           o_full,
  output logic                           o_empty,
  output logic                           o_request,
  input  logic                           i_ack,
  output logic [KEY_W-1:0]               o_key,
  output logic [PRECISION-1:0]           o_value,
`ifdef PARTITION_KV_STATS_EN
  output logic [15:0]                    o_sent_count,
`endif
  output logic                           o_overflow
);
  localparam int VAL_W = PRECISION * DIMENSION;
  localparam logic [7:0] LAST_D = 8'(DIMENSION - 1);
  state_t               state_q, state_d;
  logic [7:0]           d_q, d_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic [VAL_W-1:0]     shadow_q, shadow_d;
  logic [PRECISION-1:0] val_q, val_d;
  logic                 ovf_q, ovf_d;
  logic [KEY_W+VAL_W-1:0] head;
  logic [ADDR_W:0]      count;
  logic                 full, empty, pop, last;

  kv_sync_fifo #(.WIDTH(KEY_W + VAL_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (i_wr_en),
    .wr_data ({i_key, i_value}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      d_q      <= '0;
      key_q    <= '0;
      shadow_q <= '0;
      val_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      d_q      <= d_d;
      key_q    <= key_d;
      shadow_q <= shadow_d;
      val_q    <= val_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    pop     = state_q == REQ && i_ack;
    last    = state_q == SEND && d_q == LAST_D;
    state_d = state_q;
    d_d     = d_q;
    case (state_q)
      IDLE: state_d = count != '0 ? REQ : IDLE;
      REQ:  state_d = i_ack ? HOLD : REQ;
      HOLD: begin
        state_d = SEND;
        d_d     = 8'd0;
      end
      default: begin
        state_d = !last ? SEND : count != '0 ? REQ : IDLE;
        d_d     = d_q + 8'd1;
      end
    endcase
  end

  // Dimension 0 is loaded at the ack so it shows in HOLD; each SEND cycle preloads the next one.
  always_comb begin
    key_d    = pop ? head[KEY_W+VAL_W-1 -: KEY_W] : key_q;
    shadow_d = pop ? head[VAL_W-1:0] : shadow_q;
    val_d    = pop ? head[PRECISION-1:0]
             : (state_q == SEND && !last) ? shadow_q[(d_q + 8'd1) * PRECISION +: PRECISION]
             : val_q;
    ovf_d    = ovf_q | (i_wr_en && full && !pop);
  end

`ifdef PARTITION_KV_STATS_EN
  logic [15:0] sent_q, sent_d;
  always_comb sent_d = last ? sent_q + 16'd1 : sent_q;
  always_ff @(posedge clock) begin
    if (!reset_n) sent_q <= '0;
    else sent_q <= sent_d;
  end
  assign o_sent_count = sent_q;
`endif

  always_comb begin
    o_request  = state_q == REQ;
    o_key      = key_q;
    o_value    = val_q;
    o_overflow = ovf_q;
    o_full     = full;
    o_empty    = empty && (state_q == IDLE || state_q == REQ);
  end
endmodule

// File: tb/tb_partition_kv_sender.sv
// tb_partition_kv_sender: randomized self-checking bench; a queue of pushed pairs is the
// reference, and each ack is expected to produce DIMENSION+1 idle-request lane cycles.
`timescale 1ns/1ps
module tb_partition_kv_sender;
  localparam int P = 16, DIM = 2, DEP = 8;
  logic clock = 1'b0, reset_n = 1'b0, i_wr_en = 1'b0, i_ack = 1'b0;
  logic [15:0] i_key = '0;
  logic [P*DIM-1:0] i_value = '0;
  logic o_full, o_empty, o_request, o_overflow;
  logic [15:0] o_key;
  logic [P-1:0] o_value;
`ifdef PARTITION_KV_STATS_EN
  logic [15:0] o_sent_count;
`endif
  typedef struct {logic [15:0] k; logic [P*DIM-1:0] v;} pair_t;
  pair_t q[$];
  pair_t exp_p;
  bit m_ovf;
  int n_cmp = 0, n_fail = 0;
  logic obs_req [DIM+1];
  logic [15:0] obs_key [DIM+1];
  logic [P-1:0] obs_val [DIM+1];

  partition_kv_sender #(.PRECISION(P), .DIMENSION(DIM), .DEPTH(DEP), .ADDR_W(3)) dut (
    .clock(clock), .reset_n(reset_n), .i_wr_en(i_wr_en), .i_key(i_key), .i_value(i_value),
    .o_full(o_full), .o_empty(o_empty), .o_request(o_request), .i_ack(i_ack),
    .o_key(o_key), .o_value(o_value),
`ifdef PARTITION_KV_STATS_EN
    .o_sent_count(o_sent_count),
`endif
    .o_overflow(o_overflow));

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [P-1:0] dim_of(input logic [P*DIM-1:0] v, input int d);
    return v[d*P +: P];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; i_wr_en = 1'b0; i_ack = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic push(input logic [15:0] k, input logic [P*DIM-1:0] v);
    i_wr_en = 1'b1; i_key = k; i_value = v;
    tick();
    i_wr_en = 1'b0;
    if (q.size() < DEP) q.push_back('{k, v}); else m_ovf = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) if (o_request) ok = 1'b1; else tick();
  endtask

  // Acks now (optionally pushing in the same cycle) and records cycles T+1 .. T+1+DIM.
  task automatic ack_capture(input bit wr, input logic [15:0] k, input logic [P*DIM-1:0] v);
    i_ack = 1'b1; i_wr_en = wr; i_key = k; i_value = v;
    tick();
    i_ack = 1'b0; i_wr_en = 1'b0;
    exp_p = q.pop_front();
    if (wr) q.push_back('{k, v});
    for (int c = 0; c <= DIM; c++) begin
      obs_req[c] = o_request; obs_key[c] = o_key; obs_val[c] = o_value;
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    n_cmp++; if (o_request !== 1'b0) begin n_fail++; $display("FAIL reset_request: got %b want 0", o_request); end
    n_cmp++; if (o_key !== 16'h0) begin n_fail++; $display("FAIL reset_key: got %h want 0000", o_key); end
    n_cmp++; if (o_value !== '0) begin n_fail++; $display("FAIL reset_value: got %h want 0", o_value); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", o_overflow); end
    n_cmp++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", o_full); end
    n_cmp++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", o_empty); end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    push(16'h0005, (P*DIM)'(32'hBBBB_AAAA));
    wait_req(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_req_rise: request=0 want 1"); end
    tick(); tick();
    n_cmp++; if (o_request !== 1'b1) begin n_fail++; $display("FAIL single_req_held: got %b want 1", o_request); end
    ack_capture(1'b0, 16'h0, '0);
    n_cmp++; if (obs_req[0] !== 1'b0) begin n_fail++; $display("FAIL single_req_drop: got %b want 0", obs_req[0]); end
    n_cmp++; if (obs_val[0] !== 16'hAAAA) begin n_fail++; $display("FAIL single_val_t1: got %h want aaaa", obs_val[0]); end
    n_cmp++; if (obs_val[1] !== 16'hAAAA) begin n_fail++; $display("FAIL single_val_t2: got %h want aaaa", obs_val[1]); end
    n_cmp++; if (obs_val[2] !== 16'hBBBB) begin n_fail++; $display("FAIL single_val_t3: got %h want bbbb", obs_val[2]); end
    for (int c = 0; c <= DIM; c++) begin
      n_cmp++; if (obs_key[c] !== 16'h0005) begin n_fail++; $display("FAIL single_key c=%0d: got %h want 0005", c, obs_key[c]); end
    end
    n_cmp++; if (o_request !== 1'b0) begin n_fail++; $display("FAIL single_idle_req: got %b want 0", o_request); end
    n_cmp++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL single_idle_empty: got %b want 1", o_empty); end
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    tick();
    n_cmp++; if (o_request !== 1'b0 || o_key !== 16'h0005 || o_value !== 16'hBBBB)
      begin n_fail++; $display("FAIL stray_ack: req=%b key=%h val=%h want req=0 key=0005 val=bbbb", o_request, o_key, o_value); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) push(16'($urandom), (P*DIM)'($urandom));
    wait_req(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b_req_rise: request=0 want 1"); end
    for (int i = 0; i < 3; i++) begin
      ack_capture(1'b0, 16'h0, '0);
      for (int c = 0; c <= DIM; c++) begin
        int e = (c == 0) ? 0 : c - 1;
        n_cmp++;
        if (obs_req[c] !== 1'b0 || obs_key[c] !== exp_p.k || obs_val[c] !== dim_of(exp_p.v, e)) begin
          n_fail++;
          $display("FAIL b2b_xfer%0d c=%0d: req=%b key=%h val=%h want req=0 key=%h val=%h",
                   i, c, obs_req[c], obs_key[c], obs_val[c], exp_p.k, dim_of(exp_p.v, e));
        end
      end
      n_cmp++; if (o_request !== (q.size() > 0))
        begin n_fail++; $display("FAIL b2b_rereq%0d: got %b want %b", i, o_request, q.size() > 0); end
    end
    n_cmp++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %b want 1", o_empty); end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      push(16'($urandom), (P*DIM)'($urandom));
      if (i == 7) begin
        n_cmp++; if (o_full !== 1'b1 || o_overflow !== 1'b0)
          begin n_fail++; $display("FAIL ovf_8th: full=%b ovf=%b want full=1 ovf=0", o_full, o_overflow); end
      end
    end
    n_cmp++; if (o_full !== 1'b1 || o_overflow !== 1'b1)
      begin n_fail++; $display("FAIL ovf_9th: full=%b ovf=%b want full=1 ovf=1", o_full, o_overflow); end
    for (int i = 0; i < 8; i++) begin
      wait_req(ok);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL ovf_drain_req%0d: request=0 want 1", i); end
      else begin
        repeat ($urandom_range(0, 2)) tick();
        ack_capture(1'b0, 16'h0, '0);
        for (int c = 0; c <= DIM; c++) begin
          int e = (c == 0) ? 0 : c - 1;
          n_cmp++;
          if (obs_req[c] !== 1'b0 || obs_key[c] !== exp_p.k || obs_val[c] !== dim_of(exp_p.v, e)) begin
            n_fail++;
            $display("FAIL ovf_drain%0d c=%0d: req=%b key=%h val=%h want req=0 key=%h val=%h",
                     i, c, obs_req[c], obs_key[c], obs_val[c], exp_p.k, dim_of(exp_p.v, e));
          end
        end
      end
    end
    n_cmp++; if (o_empty !== 1'b1 || o_overflow !== 1'b1 || o_request !== 1'b0)
      begin n_fail++; $display("FAIL ovf_end: empty=%b ovf=%b req=%b want 1 1 0", o_empty, o_overflow, o_request); end
  endtask

  task automatic test_full_push_pop();
    bit ok;
    do_reset();
    for (int i = 0; i < 8; i++) push(16'($urandom), (P*DIM)'($urandom));
    wait_req(ok);
    n_cmp++; if (!ok || o_full !== 1'b1)
      begin n_fail++; $display("FAIL fpp_pre: req=%b full=%b want 1 1", o_request, o_full); end
    ack_capture(1'b1, 16'($urandom), (P*DIM)'($urandom));
    n_cmp++; if (o_full !== 1'b1 || o_overflow !== 1'b0)
      begin n_fail++; $display("FAIL fpp_post: full=%b ovf=%b want full=1 ovf=0", o_full, o_overflow); end
    for (int c = 0; c <= DIM; c++) begin
      int e = (c == 0) ? 0 : c - 1;
      n_cmp++; if (obs_key[c] !== exp_p.k || obs_val[c] !== dim_of(exp_p.v, e))
        begin n_fail++; $display("FAIL fpp_xfer c=%0d: key=%h val=%h want key=%h val=%h", c, obs_key[c], obs_val[c], exp_p.k, dim_of(exp_p.v, e)); end
    end
    for (int i = 0; i < 8; i++) begin
      wait_req(ok);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL fpp_drain_req%0d: request=0 want 1", i); end
      else begin
        ack_capture(1'b0, 16'h0, '0);
        n_cmp++; if (obs_key[0] !== exp_p.k || obs_val[DIM] !== dim_of(exp_p.v, DIM - 1))
          begin n_fail++; $display("FAIL fpp_drain%0d: key=%h val=%h want key=%h val=%h", i, obs_key[0], obs_val[DIM], exp_p.k, dim_of(exp_p.v, DIM - 1)); end
      end
    end
    n_cmp++; if (o_empty !== 1'b1 || o_overflow !== 1'b0)
      begin n_fail++; $display("FAIL fpp_end: empty=%b ovf=%b want 1 0", o_empty, o_overflow); end
  endtask

  task automatic test_reset_mid_send();
    bit ok;
    do_reset();
    push(16'hFFFF, '1);
    push(16'h1234, (P*DIM)'($urandom));
    wait_req(ok);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    n_cmp++; if (o_request !== 1'b0 || o_key !== 16'h0 || o_value !== '0 || o_overflow !== 1'b0 || o_full !== 1'b0 || o_empty !== 1'b1)
      begin n_fail++; $display("FAIL midreset_outs: req=%b key=%h val=%h ovf=%b full=%b empty=%b want 0 0 0 0 0 1", o_request, o_key, o_value, o_overflow, o_full, o_empty); end
    reset_n = 1'b1;
    tick();
    n_cmp++; if (o_request !== 1'b0 || o_empty !== 1'b1)
      begin n_fail++; $display("FAIL midreset_after: req=%b empty=%b want 0 1", o_request, o_empty); end
    q.delete();
  endtask

  task automatic test_random();
    bit ok;
    do_reset();
    for (int it = 0; it < 30; it++) begin
      int n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) push(16'($urandom), (P*DIM)'($urandom));
      n_cmp++; if (o_overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf it=%0d: got %b want %b", it, o_overflow, m_ovf); end
      if (q.size() > 0) begin
        wait_req(ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL rnd_req it=%0d: request=0 want 1", it); end
        else begin
          repeat ($urandom_range(0, 2)) tick();
          ack_capture($urandom_range(0, 1) == 1, 16'($urandom), (P*DIM)'($urandom));
          for (int c = 0; c <= DIM; c++) begin
            int e = (c == 0) ? 0 : c - 1;
            n_cmp++;
            if (obs_req[c] !== 1'b0 || obs_key[c] !== exp_p.k || obs_val[c] !== dim_of(exp_p.v, e)) begin
              n_fail++;
              $display("FAIL rnd_xfer it=%0d c=%0d: req=%b key=%h val=%h want req=0 key=%h val=%h",
                       it, c, obs_req[c], obs_key[c], obs_val[c], exp_p.k, dim_of(exp_p.v, e));
            end
          end
          n_cmp++; if (o_request !== (q.size() > 0))
            begin n_fail++; $display("FAIL rnd_rereq it=%0d: got %b want %b", it, o_request, q.size() > 0); end
        end
      end else begin
        n_cmp++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL rnd_empty it=%0d: got %b want 1", it, o_empty); end
      end
    end
  endtask

`ifdef PARTITION_KV_STATS_EN
  task automatic test_stats();
    bit ok;
    do_reset();
    n_cmp++; if (o_sent_count !== 16'd0) begin n_fail++; $display("FAIL stats_reset: got %0d want 0", o_sent_count); end
    for (int i = 0; i < 5; i++) begin
      push(16'($urandom), (P*DIM)'($urandom));
      wait_req(ok);
      if (ok) ack_capture(1'b0, 16'h0, '0);
    end
    n_cmp++; if (o_sent_count !== 16'd5) begin n_fail++; $display("FAIL stats_count: got %0d want 5", o_sent_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_send();
    test_random();
`ifdef PARTITION_KV_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
